ex_stage: RTL
=============

# ex_stage

Execute stage of the pipelined processor plus the EX/MEM pipeline register. It consumes the fields registered by the ID/EX pipeline register and forwards operands from its own EX/MEM outputs and from the write-back stage. It selects the ALU operation from ALUOp and the instruction funct fields, and registers the result and control bits toward MEM. An optional iterative 32-cycle multiplier for RV32M MUL stalls the front of the pipeline while it is busy.

## Interface
- No parameters; datapath fixed at 32 bits, register index 5 bits.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- id_ex_ALUSrc, id_ex_MemtoReg, id_ex_MemRead, id_ex_MemWrite, id_ex_RegWrite  in  1 each  control bits from ID/EX
- id_ex_ALUOp  in  2  00 add, 01 sub, 10 R-type decode, 11 I-type decode
- ex_rs1_val, ex_rs2_val  in  32  register-file operands from ID/EX
- ex_rs1_idx, ex_rs2_idx, ex_rd  in  5  source and destination indices
- ex_imm  in  32  sign-extended immediate
- ex_instr  in  32  instruction; uses funct3 [14:12], funct7 [31:25], opcode [6:0]
- wb_RegWrite  in  1, wb_rd  in  5, wb_result  in  32  write-back forwarding source
- ex_mem_alu_result  out  32, ex_mem_store_data  out  32, ex_mem_rd  out  5  registered outputs
- ex_mem_MemtoReg, ex_mem_MemRead, ex_mem_MemWrite, ex_mem_RegWrite, ex_mem_zero  out  1  registered outputs
- stall  out  1  combinational; when 1, PC, IF/ID and ID/EX must hold their contents

## Operation
- Forwarding for rs1 and rs2, applied independently:
  - First priority: own EX/MEM output, if ex_mem_RegWrite && !ex_mem_MemRead && ex_mem_rd!=0 && ex_mem_rd==idx.
  - Second priority: write-back inputs, if wb_RegWrite && wb_rd!=0 && wb_rd==idx.
  - Otherwise: the ID/EX operand value.
- Operand B = ex_imm if id_ex_ALUSrc, else forwarded rs2.
- ex_mem_store_data is always forwarded rs2.
- ALU operation by ALUOp:
  - 00: ADD.
  - 01: SUB.
  - 10: funct3 000 ADD or SUB (SUB when funct7[5]), 001 SLL, 010 SLT signed, 011 SLTU, 100 XOR, 101 SRL or SRA (SRA when funct7[5]), 110 OR, 111 AND.
  - 11: same funct3 map, but 000 is always ADD; funct7[5] selects SRA only for 101.
- Shift amount is B[4:0]. SLT/SLTU produce 32'h1 or 32'h0. Arithmetic wraps modulo 2^32.
- ex_mem_zero = (result==0).
- MUL detection: opcode 0110011, funct7 0000001, funct3 000. MUL produces the low 32 bits of the product.
- Multiplier FSM, states IDLE and BUSY:
  - IDLE with a MUL present: latch forwarded operands into mcand/mplier, clear acc, cnt=0, go to BUSY, write a bubble into EX/MEM.
  - BUSY: each cycle acc += mplier[cnt] ? mcand<<cnt : 0, then cnt++.
  - BUSY with cnt==31: final step; write acc into EX/MEM together with the MUL's rd and control bits; return to IDLE.
- stall = (IDLE && MUL) || (BUSY && cnt!=31).
- Bubble: RegWrite, MemRead, MemWrite and MemtoReg registered as 0; data fields don't-care but registered as 0.

## Timing
- Reset: all ex_mem_* outputs 0, state IDLE, cnt 0, acc 0. stall then follows the combinational equation, so it is 0 unless a MUL is present.
- Non-MUL latency: 1 cycle; inputs sampled at edge N appear on ex_mem_* after edge N.
- MUL arrives in cycle 0:
  - stall high in cycles 0-31.
  - Bubbles written at edges 0-31.
  - Result written at edge 32; stall low in cycle 32, so upstream advances at that edge.
  - MUL occupies EX for 33 cycles.
- Operands are latched in cycle 0, so changes to wb_* during BUSY do not affect the product.
- Forwarding from own outputs during BUSY is unaffected because bubbles carry RegWrite=0.
- Reset mid-MUL: FSM returns to IDLE at once, partial product discarded, outputs cleared. The stall output re-evaluates combinationally.
- Back-to-back MULs: the second one enters IDLE in cycle 33 and starts a fresh 33-cycle sequence.

## Configuration
- EX_MUL_EN defined: multiplier FSM and stall logic are compiled in as described.
- EX_MUL_EN undefined:
  - No FSM; stall tied 0.
  - The MUL encoding executes in 1 cycle and yields ex_mem_alu_result 32'h0, with its control bits passed through.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7, ALUOp 10 -> next edge ex_mem_alu_result=12, ex_mem_rd=3, ex_mem_RegWrite=1, ex_mem_zero=0.
- SUB via ALUOp 01, rs1=rs2=9 -> result 0, ex_mem_zero=1. SRA with rs1=32'h80000000, imm shamt 4, ALUOp 11, funct7[5]=1 -> 32'hF8000000.
- Forwarding:
  - Previous ALU result 20 to x5, current rs1_idx=5, stale rs1_val=1, wb_rd=5 with wb_result=99 -> EX/MEM source wins, result uses 20.
  - With the previous instruction a load instead -> wb value 99 is used.
- MUL 6×7 (EX_MUL_EN) -> stall high 32 cycles, 32 bubbles with RegWrite=0, then ex_mem_alu_result=42 and RegWrite=1. MUL 32'hFFFFFFFF×32'hFFFFFFFF -> 32'h00000001.
- rst asserted in cycle 10 of a MUL -> outputs 0 and FSM IDLE immediately. After rst release with an ADD present -> normal 1-cycle result.
- Without EX_MUL_EN, MUL 6×7 -> stall never asserts; result 32'h0 after 1 cycle.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: execute stage plus the EX/MEM pipeline register.
// Operands are forwarded from EX/MEM and WB, then fed to a 32-bit ALU.
// The ALU operation comes from ALUOp and funct3/funct7.
// Build macro EX_MUL_EN adds an iterative 32-cycle RV32M MUL unit.
// While that unit is busy it raises stall toward PC, IF/ID and ID/EX.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_ex_ALUSrc,
  input  logic        id_ex_MemtoReg,
  input  logic        id_ex_MemRead,
  input  logic        id_ex_MemWrite,
  input  logic        id_ex_RegWrite,
  input  logic [1:0]  id_ex_ALUOp,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic [4:0]  ex_rs1_idx,
  input  logic [4:0]  ex_rs2_idx,
  input  logic [4:0]  ex_rd,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_instr,
  input  logic        wb_RegWrite,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_result,
  output logic [31:0] ex_mem_alu_result,
  output logic [31:0] ex_mem_store_data,
  output logic [4:0]  ex_mem_rd,
  output logic        ex_mem_MemtoReg,
  output logic        ex_mem_MemRead,
  output logic        ex_mem_MemWrite,
  output logic        ex_mem_RegWrite,
  output logic        ex_mem_zero,
  output logic        stall
);

  logic [2:0]  funct3;
  logic        f7b5;
  logic        is_mul;
  logic [31:0] fwd_a, fwd_b, op_b, alu_res;
  logic        unused_instr;

  assign funct3       = ex_instr[14:12];
  assign f7b5         = ex_instr[30];
  assign is_mul       = (ex_instr[6:0] == 7'b0110011) && (ex_instr[31:25] == 7'b0000001) &&
                        (funct3 == 3'b000);
  assign unused_instr = ^{ex_instr[24:15], ex_instr[11:7]};

  // EX/MEM register state
  logic [31:0] alu_q, alu_d, store_q, store_d;
  logic [4:0]  rd_q, rd_d;
  logic        m2r_q, m2r_d, mr_q, mr_d, mw_q, mw_d, rw_q, rw_d, zero_q, zero_d;

  // Operand forwarding: a load in EX/MEM has no data yet, so it is skipped
  always_comb begin
    fwd_a = ex_rs1_val;
    fwd_b = ex_rs2_val;
    if (rw_q && !mr_q && rd_q != 5'd0 && rd_q == ex_rs1_idx)
      fwd_a = alu_q;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs1_idx)
      fwd_a = wb_result;
    if (rw_q && !mr_q && rd_q != 5'd0 && rd_q == ex_rs2_idx)
      fwd_b = alu_q;
    else if (wb_RegWrite && wb_rd != 5'd0 && wb_rd == ex_rs2_idx)
      fwd_b = wb_result;
  end

  assign op_b = id_ex_ALUSrc ? ex_imm : fwd_b;

  // ALU: ALUOp 10 lets funct7[5] pick SUB; ALUOp 11 (I-type) always adds on funct3 000
  always_comb begin
    alu_res = 32'h0;
    case (id_ex_ALUOp)
      2'b00: alu_res = fwd_a + op_b;
      2'b01: alu_res = fwd_a - op_b;
      default: begin
        case (funct3)
          3'b000: alu_res = (id_ex_ALUOp == 2'b10 && f7b5) ? fwd_a - op_b : fwd_a + op_b;
          3'b001: alu_res = fwd_a << op_b[4:0];
          3'b010: alu_res = {31'h0, $signed(fwd_a) < $signed(op_b)};
          3'b011: alu_res = {31'h0, fwd_a < op_b};
          3'b100: alu_res = fwd_a ^ op_b;
          3'b101: alu_res = f7b5 ? 32'($signed(fwd_a) >>> op_b[4:0]) : fwd_a >> op_b[4:0];
          3'b110: alu_res = fwd_a | op_b;
          default: alu_res = fwd_a & op_b;
        endcase
      end
    endcase
  end

  logic        bubble;
  logic [31:0] res_sel;

`ifdef EX_MUL_EN
  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic        wr_mul;

  // Shift-add multiplier FSM; operands are captured once so later WB traffic cannot disturb them
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    stall    = 1'b0;
    bubble   = 1'b0;
    wr_mul   = 1'b0;
    case (state_q)
      S_IDLE: if (is_mul) begin
        mcand_d  = fwd_a;
        mplier_d = fwd_b;
        acc_d    = 32'h0;
        cnt_d    = 5'd0;
        state_d  = S_BUSY;
        stall    = 1'b1;
        bubble   = 1'b1;
      end
      default: begin
        acc_d = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : 32'h0);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          wr_mul  = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall  = 1'b1;
          bubble = 1'b1;
        end
      end
    endcase
  end

  // Multiplier state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 32'h0;
      mcand_q  <= 32'h0;
      mplier_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  assign res_sel = wr_mul ? acc_d : alu_res;
`else
  // Without the multiplier, MUL completes in one cycle with a zero result
  assign stall   = 1'b0;
  assign bubble  = 1'b0;
  assign res_sel = is_mul ? 32'h0 : alu_res;
`endif

  // Next EX/MEM contents: a bubble clears control and data
  always_comb begin
    alu_d   = res_sel;
    store_d = fwd_b;
    rd_d    = ex_rd;
    m2r_d   = id_ex_MemtoReg;
    mr_d    = id_ex_MemRead;
    mw_d    = id_ex_MemWrite;
    rw_d    = id_ex_RegWrite;
    zero_d  = (res_sel == 32'h0);
    if (bubble) begin
      alu_d   = 32'h0;
      store_d = 32'h0;
      rd_d    = 5'd0;
      m2r_d   = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      rw_d    = 1'b0;
      zero_d  = 1'b0;
    end
  end

  // EX/MEM pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_q   <= 32'h0;
      store_q <= 32'h0;
      rd_q    <= 5'd0;
      m2r_q   <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      rw_q    <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      store_q <= store_d;
      rd_q    <= rd_d;
      m2r_q   <= m2r_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      rw_q    <= rw_d;
      zero_q  <= zero_d;
    end
  end

  assign ex_mem_alu_result = alu_q;
  assign ex_mem_store_data = store_q;
  assign ex_mem_rd         = rd_q;
  assign ex_mem_MemtoReg   = m2r_q;
  assign ex_mem_MemRead    = mr_q;
  assign ex_mem_MemWrite   = mw_q;
  assign ex_mem_RegWrite   = rw_q;
  assign ex_mem_zero       = zero_q;

endmodule
